// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile
// APB slave register bank: NUM_REGS read/write control words at word offsets
// 0..NUM_REGS-1, plus a read-only live status word at offset NUM_REGS.
// Bad address, misalignment or a write to the status word answer with PSLVERR.
// Optional macro APB_SLV_WAIT_EN compiles in a WAIT state with a 4-bit
// down-counter that holds off o_pready for WAIT_CYCLES access cycles.
// Without the macro every transfer completes in its first access cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_IDLE | no transfer in flight; watching for a setup cycle
// ST_WAIT | transfer latched, counting wait states (APB_SLV_WAIT_EN only)
// ST_RESP | o_pready high this cycle; completes or aborts at the next edge
module apb_slave_regfile #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_REGS    = 4,
    parameter int                    WAIT_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                           i_clk_apb,
    input  logic                           i_rstn_apb,
    input  logic                           i_psel,
    input  logic                           i_penable,
    input  logic                           i_pwrite,
    input  logic [ADDR_WIDTH-1:0]          i_paddr,
    input  logic [DATA_WIDTH-1:0]          i_pwdata,
    output logic [DATA_WIDTH-1:0]          o_prdata,
    output logic                           o_pready,
    output logic                           o_pslverr,
    input  logic [DATA_WIDTH-1:0]          i_status,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);

`ifdef APB_SLV_WAIT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd2
    } state_t;
`endif

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
`ifdef APB_SLV_WAIT_EN
    logic [3:0]              cnt_q, cnt_d;
`endif

    logic                    setup;
    logic                    complete;
    logic                    take_setup;
    logic                    wr_en;
    logic [IDX_W-1:0]        live_idx;
    logic                    live_err;
    logic [IDX_W-1:0]        rd_idx;
    logic [DATA_WIDTH-1:0]   rd_data;

    assign setup    = i_psel & ~i_penable;
    assign complete = (state_q == ST_RESP) & i_psel & i_penable & pready_q;
    assign live_idx = i_paddr[ADDR_WIDTH-1:2];
    assign live_err = (i_paddr[1:0] != 2'b00)
                    | (live_idx > STATUS_IDX)
                    | (i_pwrite & (live_idx == STATUS_IDX));

    // While waiting, the read is taken from the latched address; otherwise
    // the setup-cycle address is still on the bus and is used directly.
`ifdef APB_SLV_WAIT_EN
    assign rd_idx = (state_q == ST_WAIT) ? addr_q : live_idx;
`else
    assign rd_idx = live_idx;
`endif

    // Read mux over the R/W registers and the status word.
    always_comb begin
        rd_data = '0;
        if (rd_idx == STATUS_IDX) begin
            rd_data = i_status;
        end
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_idx == IDX_W'(k)) begin
                rd_data = regs_q[k];
            end
        end
    end

    // Next-state and registered-output logic for the transfer FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        pready_d   = 1'b0;
        pslverr_d  = 1'b0;
        prdata_d   = '0;
        wr_en      = 1'b0;
        take_setup = 1'b0;
`ifdef APB_SLV_WAIT_EN
        cnt_d      = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                take_setup = setup;
            end
`ifdef APB_SLV_WAIT_EN
            ST_WAIT: begin
                if (!i_psel) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d   = ST_RESP;
                    cnt_d     = 4'd0;
                    pready_d  = 1'b1;
                    pslverr_d = err_q;
                    prdata_d  = (err_q | write_q) ? '0 : rd_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            ST_RESP: begin
                // Always leave RESP: either the transfer completes, or the
                // master dropped psel and the transfer is abandoned.
                state_d    = ST_IDLE;
                wr_en      = complete & write_q & ~err_q;
                take_setup = setup;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_setup) begin
            addr_d  = live_idx;
            write_d = i_pwrite;
            wdata_d = i_pwdata;
            err_d   = live_err;
`ifdef APB_SLV_WAIT_EN
            if (WAIT_CYCLES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = 4'(WAIT_CYCLES);
            end else begin
                state_d   = ST_RESP;
                pready_d  = 1'b1;
                pslverr_d = live_err;
                prdata_d  = (live_err | i_pwrite) ? '0 : rd_data;
            end
`else
            state_d   = ST_RESP;
            pready_d  = 1'b1;
            pslverr_d = live_err;
            prdata_d  = (live_err | i_pwrite) ? '0 : rd_data;
`endif
        end
    end

    // FSM state, latched transfer and registered response outputs.
    always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
        if (!i_rstn_apb) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= 4'd0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
`ifdef APB_SLV_WAIT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Register bank; written only at the completing edge with the latched data.
    always_ff @(posedge i_clk_apb or negedge i_rstn_apb) begin
        if (!i_rstn_apb) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
        end else if (wr_en) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (addr_q == IDX_W'(k)) begin
                    regs_q[k] <= wdata_q;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign o_regs[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    assign o_prdata  = prdata_q;
    assign o_pready  = pready_q;
    assign o_pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: directed scenarios plus randomized APB
// transfers checked every cycle against a transaction-level model.
module tb_apb_slave_regfile;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 4;
`ifdef APB_SLV_WAIT_EN
    localparam int WAITS = 2;
`else
    localparam int WAITS = 0;
`endif
    localparam logic [31:0] RST_VAL = 32'hC0DE_0000;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            psel = 1'b0;
    logic            penable = 1'b0;
    logic            pwrite = 1'b0;
    logic [AW-1:0]   paddr = '0;
    logic [DW-1:0]   pwdata = '0;
    logic [DW-1:0]   status = '0;
    logic [DW-1:0]   prdata;
    logic            pready;
    logic            pslverr;
    logic [NR*DW-1:0] regs;

    always #5 clk = ~clk;

    apb_slave_regfile #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .WAIT_CYCLES(2),
        .RESET_VAL  (RST_VAL)
    ) dut (
        .i_clk_apb (clk),
        .i_rstn_apb(rstn),
        .i_psel    (psel),
        .i_penable (penable),
        .i_pwrite  (pwrite),
        .i_paddr   (paddr),
        .i_pwdata  (pwdata),
        .o_prdata  (prdata),
        .o_pready  (pready),
        .o_pslverr (pslverr),
        .i_status  (status),
        .o_regs    (regs)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model_regs [NR];
    logic        exp_pready   = 1'b0;
    logic        exp_pslverr  = 1'b0;
    logic [31:0] exp_prdata   = '0;
    logic        exp_data_chk = 1'b1;
    bit          pend_valid   = 1'b0;
    int          pend_idx     = 0;
    logic [31:0] pend_data    = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [NR*DW-1:0] model_flat();
        logic [NR*DW-1:0] f;
        for (int k = 0; k < NR; k++) f[k*DW +: DW] = model_regs[k];
        return f;
    endfunction

    // Per-cycle comparison of DUT outputs against the model expectations.
    always @(negedge clk) begin
        chk("pready", pready, exp_pready);
        if (exp_pready) chk("pslverr", pslverr, exp_pslverr);
        if (exp_data_chk) chk("prdata", prdata, exp_prdata);
        chk("regs", regs, model_flat());
    end

    task automatic set_exp(input logic r, input logic e, input logic [31:0] d, input logic c);
        exp_pready   = r;
        exp_pslverr  = e;
        exp_prdata   = d;
        exp_data_chk = c;
    endtask

    // Advance to just after the next rising edge; a write that completed on
    // that edge becomes visible in the model.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        if (pend_valid) begin
            model_regs[pend_idx] = pend_data;
            pend_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            psel    = 1'b0;
            penable = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            pwrite = 1'($urandom_range(0, 1));
            paddr  = $urandom;
            pwdata = $urandom;
            set_exp(1'b0, 1'b0, '0, 1'b1);
        end
    endtask

    // One APB transfer; abort_at = access cycle in which psel is dropped (-1: none).
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input int abort_at, input logic [31:0] st,
                        output logic seen_rdy, output logic seen_err, output logic [31:0] seen_data);
        logic [31:0] widx;
        bit          err;
        logic [31:0] rd;
        seen_rdy  = 1'b0;
        seen_err  = 1'b0;
        seen_data = '0;
        next_cycle();
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        status  = st;
        set_exp(1'b0, 1'b0, '0, 1'b1);
        widx = addr >> 2;
        err  = (addr[1:0] != 2'b00) || (widx > NR) || (wr && widx == NR);
        if (err || wr)       rd = '0;
        else if (widx == NR) rd = st;
        else                 rd = model_regs[widx];
        for (int n = 0; n <= WAITS; n++) begin
            next_cycle();
            pwdata = $urandom;
            if (n == abort_at) begin
                psel    = 1'b0;
                penable = 1'b0;
            end else begin
                penable = 1'b1;
            end
            if (n == WAITS) set_exp(1'b1, err, rd, !(wr && !err));
            else            set_exp(1'b0, 1'b0, '0, 1'b1);
            if (n == WAITS) begin
                #2;
                seen_rdy  = pready;
                seen_err  = pslverr;
                seen_data = prdata;
            end
            if (n == abort_at) return;
        end
        if (wr && !err) begin
            pend_valid = 1'b1;
            pend_idx   = int'(widx);
            pend_data  = data;
        end
    endtask

    initial begin
        logic        r;
        logic        e;
        logic [31:0] d;
        bit          wr;
        int          sel;
        int          ab;
        logic [31:0] addr;
        logic [31:0] b2b_addr [3];
        logic [31:0] bad_addr [3];

        for (int k = 0; k < NR; k++) model_regs[k] = RST_VAL;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pready", pready, 1'b0);
        chk("reset_prdata", prdata, 32'h0);
        chk("reset_regs", regs, {4{32'hC0DE_0000}});
        rstn = 1'b1;
        idle(2);

        // write then read word 1
        xfer(1'b1, 32'h4, 32'hA5A5_0001, -1, 32'h0, r, e, d);
        chk("t1_wr_rdy", r, 1'b1);
        chk("t1_wr_err", e, 1'b0);
        xfer(1'b0, 32'h4, 32'h0, -1, 32'h0, r, e, d);
        chk("t1_rd_rdy", r, 1'b1);
        chk("t1_rd_err", e, 1'b0);
        chk("t1_rd_data", d, 32'hA5A5_0001);
        idle(1);
        chk("t1_regs1", regs[63:32], 32'hA5A5_0001);

        // status word
        xfer(1'b0, 32'h10, 32'h0, -1, 32'hDEAD_BEEF, r, e, d);
        chk("t2_status", d, 32'hDEAD_BEEF);
        chk("t2_err", e, 1'b0);

        // error writes
        bad_addr[0] = 32'h10;
        bad_addr[1] = 32'h14;
        bad_addr[2] = 32'h6;
        for (int i = 0; i < 3; i++) begin
            xfer(1'b1, bad_addr[i], 32'hFFFF_FFFF, -1, 32'h0, r, e, d);
            chk("t3_err_rdy", r, 1'b1);
            chk("t3_err", e, 1'b1);
            chk("t3_err_data", d, 32'h0);
        end
        idle(1);
        chk("t3_regs1", regs[63:32], 32'hA5A5_0001);

        // untouched register returns reset value
        xfer(1'b0, 32'h0, 32'h0, -1, 32'h0, r, e, d);
        chk("t4_rstval", d, 32'hC0DE_0000);

        // back-to-back
        b2b_addr[0] = 32'h0;
        b2b_addr[1] = 32'h8;
        b2b_addr[2] = 32'h0;
        xfer(1'b1, b2b_addr[0], 32'h1, -1, 32'h0, r, e, d);
        xfer(1'b1, b2b_addr[1], 32'h2, -1, 32'h0, r, e, d);
        xfer(1'b0, b2b_addr[2], 32'h0, -1, 32'h0, r, e, d);
        chk("t5_rd0", d, 32'h1);
        idle(1);
        chk("t5_regs2", regs[95:64], 32'h2);

        // async reset in the middle of a write
        xfer(1'b1, 32'hC, 32'h1234, -1, 32'h0, r, e, d);
        idle(1);
        chk("t6_pre_regs3", regs[127:96], 32'h1234);
        next_cycle();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h55;
        set_exp(1'b0, 1'b0, '0, 1'b1);
        next_cycle();
        penable = 1'b1;
        set_exp(WAITS == 0, 1'b0, '0, 1'b0);
        #2;
        rstn = 1'b0;
        for (int k = 0; k < NR; k++) model_regs[k] = RST_VAL;
        pend_valid = 1'b0;
        set_exp(1'b0, 1'b0, '0, 1'b1);
        #1;
        chk("t6_rst_pready", pready, 1'b0);
        chk("t6_rst_prdata", prdata, 32'h0);
        chk("t6_rst_regs3", regs[127:96], 32'hC0DE_0000);
        psel = 1'b0;
        penable = 1'b0;
        next_cycle();
        next_cycle();
        rstn = 1'b1;
        idle(2);
        chk("t6_post_regs3", regs[127:96], 32'hC0DE_0000);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            wr  = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel < 6)       addr = 32'($urandom_range(0, NR - 1)) << 2;
            else if (sel == 6) addr = (32'($urandom_range(0, NR)) << 2) | 32'($urandom_range(1, 3));
            else if (sel == 7) addr = 32'h14 + (32'($urandom_range(0, 15)) << 2);
            else if (sel == 8) addr = $urandom;
            else               addr = 32'h10;
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, WAITS) : -1;
            xfer(wr, addr, $urandom, ab, $urandom, r, e, d);
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
